// File: rtl/ripple_count_monitor_if.sv
// Valid/ready output channel of ripple_count_monitor: one accepted counter
// sample (value plus wrap marker) per handshake.
interface ripple_count_monitor_if #(
  parameter int WIDTH = 4
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_value;
  logic             out_wrap;

  modport master (
    output out_valid,
    output out_value,
    output out_wrap,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_value,
    input  out_wrap,
    output out_ready
  );
endinterface

// File: rtl/ripple_count_monitor.sv
// Samples an asynchronous ripple counter, rejects ripple transients, checks
// each settled step for wrap/skip and hands samples out through a 2-deep buffer.
module ripple_count_monitor #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      cnt_in,
  input  logic                  down,
  ripple_count_monitor_if.master out_if,
  output logic [WRAP_WIDTH-1:0] wrap_count,
  output logic                  err_skip,
  output logic                  err_ovf
);

  localparam int              RUN_W   = 3;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_HIT = RUN_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [WIDTH-1:0]      sync1_q, sync1_d;
  logic [WIDTH-1:0]      sync2_q, sync2_d;
  logic [WIDTH-1:0]      last_q, last_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [WRAP_WIDTH-1:0] wrap_count_q, wrap_count_d;
  logic                  err_skip_q, err_skip_d;
  logic                  err_ovf_q, err_ovf_d;
  logic [1:0]            state_q, state_d;
  logic [WIDTH-1:0]      out_value_q, out_value_d;
  logic                  out_wrap_q, out_wrap_d;
  logic [WIDTH-1:0]      pend_value_q, pend_value_d;
  logic                  pend_wrap_q, pend_wrap_d;

  logic             same;
  logic             accept;
  logic [WIDTH-1:0] delta;
  logic             step_wrap;
  logic             handshake;

  // Two-flop synchronizer followed by the run-length stability filter.
  always_comb begin
    sync1_d = cnt_in;
    sync2_d = sync1_q;
    last_d  = sync2_q;
    same    = (sync2_q == last_q);
    run_d   = '0;
    if (same) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    end
    // Fires exactly once per settled value; acc then matches sync2.
    accept = (run_q == RUN_HIT) && same && (sync2_q != acc_q);
    acc_d  = accept ? sync2_q : acc_q;
  end

  // Step check against the previously accepted value.
  always_comb begin
    delta        = down ? (acc_q - sync2_q) : (sync2_q - acc_q);
    step_wrap    = down ? (sync2_q > acc_q) : (sync2_q < acc_q);
    wrap_count_d = wrap_count_q + WRAP_WIDTH'(accept && step_wrap);
    err_skip_d   = err_skip_q | (accept && (delta != WIDTH'(1)));
  end

  // Output register plus one pending slot; pending is the newer sample.
  always_comb begin
    handshake    = (state_q != ST_EMPTY) && out_if.out_ready;
    state_d      = state_q;
    out_value_d  = out_value_q;
    out_wrap_d   = out_wrap_q;
    pend_value_d = pend_value_q;
    pend_wrap_d  = pend_wrap_q;
    err_ovf_d    = err_ovf_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_value_d = sync2_q;
          out_wrap_d  = step_wrap;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && handshake) begin
          out_value_d = sync2_q;
          out_wrap_d  = step_wrap;
        end else if (accept) begin
          pend_value_d = sync2_q;
          pend_wrap_d  = step_wrap;
          state_d      = ST_TWO;
        end else if (handshake) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (handshake) begin
          out_value_d = pend_value_q;
          out_wrap_d  = pend_wrap_q;
          if (accept) begin
            pend_value_d = sync2_q;
            pend_wrap_d  = step_wrap;
          end else begin
            state_d = ST_ONE;
          end
        end else if (accept) begin
          // Consumer stalled with both slots full: newest sample wins.
          pend_value_d = sync2_q;
          pend_wrap_d  = step_wrap;
          err_ovf_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      last_q       <= '0;
      run_q        <= '0;
      acc_q        <= '0;
      wrap_count_q <= '0;
      err_skip_q   <= 1'b0;
      err_ovf_q    <= 1'b0;
      state_q      <= ST_EMPTY;
      out_value_q  <= '0;
      out_wrap_q   <= 1'b0;
      pend_value_q <= '0;
      pend_wrap_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      last_q       <= last_d;
      run_q        <= run_d;
      acc_q        <= acc_d;
      wrap_count_q <= wrap_count_d;
      err_skip_q   <= err_skip_d;
      err_ovf_q    <= err_ovf_d;
      state_q      <= state_d;
      out_value_q  <= out_value_d;
      out_wrap_q   <= out_wrap_d;
      pend_value_q <= pend_value_d;
      pend_wrap_q  <= pend_wrap_d;
    end
  end

  assign out_if.out_valid = (state_q != ST_EMPTY);
  assign out_if.out_value = out_value_q;
  assign out_if.out_wrap  = out_wrap_q;
  assign wrap_count       = wrap_count_q;
  assign err_skip         = err_skip_q;
  assign err_ovf          = err_ovf_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed and random stimulus for ripple_count_monitor, checked every cycle
// against a sample-window / two-slot queue reference model.
module tb_ripple_count_monitor;

  localparam int W = 4;
  localparam int S = 2;

  typedef struct packed {
    logic [W-1:0] v;
    logic         w;
  } samp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] cnt_in;
  logic         down;
  logic         ready;
  logic [7:0]   wrap_count;
  logic         err_skip;
  logic         err_ovf;

  ripple_count_monitor_if #(.WIDTH(W)) mon_if ();
  assign mon_if.out_ready = ready;

  ripple_count_monitor #(.WIDTH(W), .STABLE_CYCLES(S), .WRAP_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .down       (down),
    .out_if     (mon_if.master),
    .wrap_count (wrap_count),
    .err_skip   (err_skip),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  samp_t buf_q[$];
  samp_t dut_seen[$];
  int    hist[$];
  int    m_acc;
  int    m_wraps;
  bit    m_skip;
  bit    m_ovf;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a value is accepted when the S+1 samples ending two edges ago
  // are all equal and differ from the last accepted value.
  task automatic edge_model();
    bit    hs;
    bit    stable;
    int    hv;
    int    d;
    samp_t s;
    if (reset) begin
      buf_q.delete();
      hist.delete();
      for (int k = 0; k < S + 2; k++) hist.push_back(0);
      m_acc = 0; m_wraps = 0; m_skip = 0; m_ovf = 0;
    end else begin
      hs     = (buf_q.size() > 0) && ready;
      hv     = hist[hist.size() - 2];
      stable = 1;
      for (int k = 2; k <= S + 2; k++) if (hist[hist.size() - k] != hv) stable = 0;
      if (hs) buf_q.delete(0);
      if (stable && hv != m_acc) begin
        d   = down ? (m_acc - hv + 16) % 16 : (hv - m_acc + 16) % 16;
        s.v = W'(hv);
        s.w = down ? (hv > m_acc) : (hv < m_acc);
        if (s.w) m_wraps = (m_wraps + 1) % 256;
        if (d != 1) m_skip = 1;
        if (buf_q.size() == 2) begin
          buf_q[1] = s;
          m_ovf    = 1;
        end else begin
          buf_q.push_back(s);
        end
        m_acc = hv;
      end
      hist.push_back(int'(cnt_in));
      hist.delete(0);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(mon_if.out_valid), 32'(buf_q.size() > 0));
    if (buf_q.size() > 0) begin
      chk("out_value", 32'(mon_if.out_value), 32'(buf_q[0].v));
      chk("out_wrap", 32'(mon_if.out_wrap), 32'(buf_q[0].w));
    end
    chk("wrap_count", 32'(wrap_count), 32'(m_wraps));
    chk("err_skip", 32'(err_skip), 32'(m_skip));
    chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
  endtask

  task automatic cycle(int n);
    bit    hs;
    samp_t s;
    repeat (n) begin
      hs  = mon_if.out_valid && ready && !reset;
      s.v = mon_if.out_value;
      s.w = mon_if.out_wrap;
      @(posedge clk);
      edge_model();
      if (hs) dut_seen.push_back(s);
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic hold(int v, int n);
    cnt_in = W'(v);
    cycle(n);
  endtask

  task automatic do_reset(bit dir, int n);
    reset  = 1'b1;
    cnt_in = '0;
    down   = dir;
    cycle(n);
    reset  = 1'b0;
    dut_seen.delete();
  endtask

  task automatic random_run(bit dir, int steps);
    int v;
    v = 0;
    do_reset(dir, 2);
    for (int i = 0; i < steps; i++) begin
      if ($urandom_range(0, 9) < 7) v = dir ? (v + 15) % 16 : (v + 1) % 16;
      else v = int'($urandom_range(0, 15));
      ready = ($urandom_range(0, 3) != 0);
      hold(v, int'($urandom_range(1, 6)));
    end
    ready = 1'b1;
    cycle(8);
  endtask

  initial begin
    reset = 1'b1; cnt_in = '0; down = 1'b0; ready = 1'b1;
    do_reset(1'b0, 3);
    chk("rst_valid", 32'(mon_if.out_valid), 32'd0);
    chk("rst_value", 32'(mon_if.out_value), 32'd0);
    chk("rst_wrap", 32'(mon_if.out_wrap), 32'd0);
    chk("rst_wrap_count", 32'(wrap_count), 32'd0);
    chk("rst_flags", {30'd0, err_skip, err_ovf}, 32'd0);

    // Up count through the full range and back to 0.
    for (int v = 1; v <= 16; v++) hold(v % 16, 6);
    cycle(6);
    chk("up_samples", 32'(dut_seen.size()), 32'd16);
    if (dut_seen.size() == 16) begin
      chk("up_first", 32'(dut_seen[0].v), 32'd1);
      chk("up_last", 32'(dut_seen[15].v), 32'd0);
      chk("up_last_wrap", 32'(dut_seen[15].w), 32'd1);
      chk("up_mid_wrap", 32'(dut_seen[7].w), 32'd0);
    end
    chk("up_wrap_count", 32'(wrap_count), 32'd1);
    chk("up_skip", 32'(err_skip), 32'd0);

    // Down count 0 -> 15 -> 14.
    do_reset(1'b1, 2);
    hold(15, 6);
    hold(14, 6);
    cycle(4);
    chk("dn_samples", 32'(dut_seen.size()), 32'd2);
    if (dut_seen.size() == 2) begin
      chk("dn_first", 32'({dut_seen[0].v, dut_seen[0].w}), 32'h1f);
      chk("dn_second", 32'({dut_seen[1].v, dut_seen[1].w}), 32'h1c);
    end
    chk("dn_wrap_count", 32'(wrap_count), 32'd1);

    // Glitch rejection: one-cycle 7 between 3 and 4.
    do_reset(1'b0, 2);
    hold(1, 6); hold(2, 6); hold(3, 8);
    dut_seen.delete();
    hold(7, 1);
    hold(4, 8);
    chk("glitch_samples", 32'(dut_seen.size()), 32'd1);
    if (dut_seen.size() == 1) chk("glitch_value", 32'(dut_seen[0].v), 32'd4);
    chk("glitch_skip", 32'(err_skip), 32'd0);

    // Skip 2 -> 5, flag stays sticky through normal steps.
    do_reset(1'b0, 2);
    hold(1, 6); hold(2, 6);
    dut_seen.delete();
    hold(5, 6); hold(6, 6); hold(7, 6);
    chk("skip_samples", 32'(dut_seen.size()), 32'd3);
    if (dut_seen.size() > 0) chk("skip_value", 32'(dut_seen[0].v), 32'd5);
    chk("skip_flag", 32'(err_skip), 32'd1);

    // Backpressure: 1, 2, 3 with consumer stalled, then drain.
    do_reset(1'b0, 2);
    ready = 1'b0;
    hold(1, 6); hold(2, 6); hold(3, 6);
    chk("bp_value", 32'(mon_if.out_value), 32'd1);
    chk("bp_ovf", 32'(err_ovf), 32'd1);
    ready = 1'b1;
    cycle(4);
    chk("bp_samples", 32'(dut_seen.size()), 32'd2);
    if (dut_seen.size() == 2) begin
      chk("bp_first", 32'(dut_seen[0].v), 32'd1);
      chk("bp_second", 32'(dut_seen[1].v), 32'd3);
    end
    chk("bp_drained", 32'(mon_if.out_valid), 32'd0);

    // Five wraps, fill both slots, then a one-cycle reset.
    do_reset(1'b0, 2);
    for (int r = 0; r < 5; r++) for (int v = 1; v <= 16; v++) hold(v % 16, 3);
    cycle(4);
    ready = 1'b0;
    hold(1, 5); hold(2, 5);
    chk("mid_wrap_count", 32'(wrap_count), 32'd5);
    reset = 1'b1; cnt_in = '0;
    cycle(1);
    reset = 1'b0;
    chk("mid_rst_valid", 32'(mon_if.out_valid), 32'd0);
    chk("mid_rst_value", 32'(mon_if.out_value), 32'd0);
    chk("mid_rst_wrap_count", 32'(wrap_count), 32'd0);
    ready = 1'b1;
    cycle(6);
    chk("mid_rst_quiet", 32'(mon_if.out_valid), 32'd0);

    random_run(1'b0, 150);
    random_run(1'b1, 150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
